// File: rtl/pcm_i2s_tx_if.sv
// PCM sample handshake between a producer and the I2S transmitter.
// The producer drives pcm_in/pcm_valid and the transmitter returns pcm_ready.
interface pcm_i2s_tx_if;
   logic [15:0] pcm_in;
   logic        pcm_valid;
   logic        pcm_ready;

   modport master (output pcm_in, output pcm_valid, input pcm_ready);
   modport slave  (input pcm_in, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pcm_i2s_tx.sv
// Mono 16-bit PCM to I2S serializer with a one-entry input buffer.
// Each 32-bit frame carries the same sample on the left and right channels.
module pcm_i2s_tx #(
   parameter int unsigned BCLK_HALF_DIV = 4
) (
   input  logic               clk,
   input  logic               reset,
   pcm_i2s_tx_if.slave        pcm,
   output logic               i2s_bclk,
   output logic               i2s_lrclk,
   output logic               i2s_sdata,
   output logic               frame_start,
   output logic               underrun
);

   localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF_DIV - 1);

   logic [7:0]  div_q,   div_d;
   logic        bclk_q,  bclk_d;
   logic [4:0]  bit_q,   bit_d;
   logic        lr_q,    lr_d;
   logic        sd_q,    sd_d;
   logic        fs_q,    fs_d;
   logic        ur_q,    ur_d;
   logic        ready_q, ready_d;
   logic        full_q,  full_d;
   logic [15:0] buf_q,   buf_d;
   logic [15:0] frame_q, frame_d;

   logic        tick;
   logic        fall;
   logic        accept;

   always_comb begin
      div_d   = div_q + 8'd1;
      bclk_d  = bclk_q;
      bit_d   = bit_q;
      lr_d    = lr_q;
      sd_d    = sd_q;
      fs_d    = 1'b0;
      ur_d    = 1'b0;
      full_d  = full_q;
      buf_d   = buf_q;
      frame_d = frame_q;

      tick   = (div_q == DIV_LAST);
      fall   = tick && bclk_q;
      accept = pcm.pcm_valid && ready_q;

      if (tick) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
      end

      if (fall) begin
         bit_d = bit_q + 5'd1;
         if (bit_q == 5'd31) begin
            // Load decision uses the buffer state from the start of the cycle.
            if (full_q) frame_d = buf_q;
            ur_d   = ~full_q;
            fs_d   = 1'b1;
            full_d = 1'b0;
         end
         // Both channel halves index frame[15 - bit_cnt[3:0]], i.e. the inverted low nibble.
         sd_d = frame_d[~bit_d[3:0]];
         lr_d = (bit_d >= 5'd15) && (bit_d != 5'd31);
      end

      if (accept) begin
         full_d = 1'b1;
         buf_d  = pcm.pcm_in;
      end

      ready_d = ~full_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= '0;
         bclk_q  <= 1'b0;
         bit_q   <= 5'd31;
         lr_q    <= 1'b0;
         sd_q    <= 1'b0;
         fs_q    <= 1'b0;
         ur_q    <= 1'b0;
         ready_q <= 1'b0;
         full_q  <= 1'b0;
         buf_q   <= '0;
         frame_q <= '0;
      end else begin
         div_q   <= div_d;
         bclk_q  <= bclk_d;
         bit_q   <= bit_d;
         lr_q    <= lr_d;
         sd_q    <= sd_d;
         fs_q    <= fs_d;
         ur_q    <= ur_d;
         ready_q <= ready_d;
         full_q  <= full_d;
         buf_q   <= buf_d;
         frame_q <= frame_d;
      end
   end

   assign pcm.pcm_ready = ready_q;
   assign i2s_bclk      = bclk_q;
   assign i2s_lrclk     = lr_q;
   assign i2s_sdata     = sd_q;
   assign frame_start   = fs_q;
   assign underrun      = ur_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Directed bench for pcm_i2s_tx with BCLK_HALF_DIV=2 (one bit = 4 clk, frame = 128 clk).
// Frames are captured as {bit0..bit31} words; a mono sample S must appear as {S,S}.
module tb_pcm_i2s_tx;

   localparam int unsigned HALF = 2;
   localparam int unsigned BITCLK = 2 * HALF;
   localparam logic [31:0] LR_EXP = 32'h0001_FFFE;

   logic clk = 1'b0;
   logic reset;
   logic i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun;

   int checks = 0;
   int failures = 0;

   pcm_i2s_tx_if u_if ();

   pcm_i2s_tx #(.BCLK_HALF_DIV(HALF)) dut (
      .clk         (clk),
      .reset       (reset),
      .pcm         (u_if),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_sdata   (i2s_sdata),
      .frame_start (frame_start),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      u_if.pcm_valid = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("rst_out", {26'd0, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, u_if.pcm_ready}, 32'd0);
      reset = 1'b0;
   endtask

   task automatic push_sample(input string tag, input logic [15:0] s);
      bit done = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (u_if.pcm_ready) begin
            u_if.pcm_in = s;
            u_if.pcm_valid = 1'b1;
            @(negedge clk);
            u_if.pcm_valid = 1'b0;
            done = 1;
            break;
         end
      end
      check_eq({tag, "_push_tmo"}, {31'd0, done}, 32'd1);
   endtask

   task automatic wait_frame(input string tag, output logic ur);
      bit seen = 0;
      ur = 1'bx;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (frame_start) begin
            seen = 1;
            ur = underrun;
            break;
         end
      end
      check_eq({tag, "_fs_tmo"}, {31'd0, seen}, 32'd1);
   endtask

   // Starts at the frame_start negedge; pcm_valid is released after the bit-1 sample.
   task automatic capture_frame(output logic [31:0] sd, output logic [31:0] lr,
                                output logic rdy0, output logic rdy1);
      sd = '0;
      lr = '0;
      rdy0 = u_if.pcm_ready;
      rdy1 = 1'b0;
      for (int k = 0; k < 32; k++) begin
         if (k > 0) repeat (BITCLK) @(negedge clk);
         if (k == 1) begin
            rdy1 = u_if.pcm_ready;
            u_if.pcm_valid = 1'b0;
         end
         sd[31-k] = i2s_sdata;
         lr[31-k] = i2s_lrclk;
      end
   endtask

   logic [31:0] sd, lr;
   logic        r0, r1, ur;
   logic [3:0]  fs_hist;
   int          ready_hi;

   initial begin
      reset = 1'b1;
      u_if.pcm_in = '0;
      u_if.pcm_valid = 1'b0;

      // Reset release timing and empty-buffer first frame
      do_reset();
      fs_hist = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) check_eq("ready_after_rst", {31'd0, u_if.pcm_ready}, 32'd1);
         fs_hist[i] = frame_start;
      end
      check_eq("first_fs_timing", {28'd0, fs_hist}, 32'h8);
      check_eq("first_ur", {31'd0, underrun}, 32'd1);
      capture_frame(sd, lr, r0, r1);
      check_eq("silent_sd", sd, 32'h0);
      check_eq("silent_lr", lr, LR_EXP);

      // One sample then silence: repeats with underrun
      push_sample("p7fff", 16'h7FFF);
      wait_frame("f7fff_a", ur);
      check_eq("f7fff_a_ur", {31'd0, ur}, 32'd0);
      capture_frame(sd, lr, r0, r1);
      check_eq("f7fff_a_sd", sd, 32'h7FFF_7FFF);
      wait_frame("f7fff_b", ur);
      check_eq("f7fff_b_ur", {31'd0, ur}, 32'd1);
      capture_frame(sd, lr, r0, r1);
      check_eq("f7fff_b_sd", sd, 32'h7FFF_7FFF);
      wait_frame("f7fff_c", ur);
      check_eq("f7fff_c_ur", {31'd0, ur}, 32'd1);

      // Fresh reset, sample written before first load
      do_reset();
      push_sample("pa5c3", 16'hA5C3);
      wait_frame("fa5c3", ur);
      check_eq("fa5c3_ur", {31'd0, ur}, 32'd0);
      capture_frame(sd, lr, r0, r1);
      check_eq("fa5c3_sd", sd, 32'hA5C3_A5C3);
      check_eq("fa5c3_lr", lr, LR_EXP);

      // pcm_valid held high across two samples
      u_if.pcm_in = 16'h1111;
      u_if.pcm_valid = 1'b1;
      @(negedge clk);
      check_eq("hold_ready_drop", {31'd0, u_if.pcm_ready}, 32'd0);
      u_if.pcm_in = 16'h2222;
      ready_hi = 0;
      begin
         bit seen = 0;
         for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_start) begin
               seen = 1;
               ur = underrun;
               break;
            end
            if (u_if.pcm_ready) ready_hi++;
         end
         check_eq("f1111_fs_tmo", {31'd0, seen}, 32'd1);
      end
      check_eq("hold_ready_low", ready_hi, 32'd0);
      check_eq("f1111_ur", {31'd0, ur}, 32'd0);
      capture_frame(sd, lr, r0, r1);
      check_eq("f1111_rdy_at_load", {31'd0, r0}, 32'd1);
      check_eq("f1111_rdy_after", {31'd0, r1}, 32'd0);
      check_eq("f1111_sd", sd, 32'h1111_1111);
      wait_frame("f2222", ur);
      check_eq("f2222_ur", {31'd0, ur}, 32'd0);
      capture_frame(sd, lr, r0, r1);
      check_eq("f2222_sd", sd, 32'h2222_2222);

      // Accept coinciding with the load edge while the buffer is empty
      repeat (BITCLK - 1) @(negedge clk);
      u_if.pcm_in = 16'h0F0F;
      u_if.pcm_valid = 1'b1;
      @(negedge clk);
      u_if.pcm_valid = 1'b0;
      check_eq("coinc_fs", {31'd0, frame_start}, 32'd1);
      check_eq("coinc_ur", {31'd0, underrun}, 32'd1);
      check_eq("coinc_buffered", {31'd0, u_if.pcm_ready}, 32'd0);
      capture_frame(sd, lr, r0, r1);
      check_eq("coinc_repeat_sd", sd, 32'h2222_2222);
      wait_frame("f0f0f", ur);
      check_eq("f0f0f_ur", {31'd0, ur}, 32'd0);
      capture_frame(sd, lr, r0, r1);
      check_eq("f0f0f_sd", sd, 32'h0F0F_0F0F);

      // Reset mid-frame with a buffered sample
      wait_frame("fpre", ur);
      check_eq("fpre_ur", {31'd0, ur}, 32'd1);
      push_sample("p1234", 16'h1234);
      repeat (20 * BITCLK - 2) @(negedge clk);
      check_eq("bit20_lr", {31'd0, i2s_lrclk}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_out", {26'd0, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, u_if.pcm_ready}, 32'd0);
      do_reset();
      wait_frame("fpost", ur);
      check_eq("fpost_ur", {31'd0, ur}, 32'd1);
      capture_frame(sd, lr, r0, r1);
      check_eq("fpost_sd", sd, 32'h0);
      wait_frame("fpost2", ur);
      check_eq("fpost2_ur", {31'd0, ur}, 32'd1);
      capture_frame(sd, lr, r0, r1);
      check_eq("fpost2_sd", sd, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pcm_i2s_tx.md
PCM_I2S_TX -- requirements
Module: pcm_i2s_tx

Interface
REQ-001 SHALL expose parameter BCLK_HALF_DIV, default 4, clk cycles per i2s_bclk half period; legal range 2..255.
REQ-002 SHALL expose port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL expose port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL expose port pcm_in  input  16  signed PCM sample (same format as the synth pcm_out).
REQ-005 SHALL expose port pcm_valid  input  1  producer asserts while pcm_in is valid.
REQ-006 SHALL expose port pcm_ready  output  1  high while the one-entry input buffer is empty.
REQ-007 SHALL expose port i2s_bclk  output  1  serial bit clock.
REQ-008 SHALL expose port i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-009 SHALL expose port i2s_sdata  output  1  serial data, MSB first.
REQ-010 SHALL expose port frame_start  output  1  one-clk pulse when a new frame sample is loaded.
REQ-011 SHALL expose port underrun  output  1  one-clk pulse when a frame load finds the buffer empty.

Function
REQ-012 SHALL accept a sample into the buffer on any clk edge with pcm_valid && pcm_ready; the buffer then reads full and pcm_ready drops the next cycle.
REQ-013 SHALL hold pcm_in stable-independent: a sample is captured only at the accept edge; pcm_valid without pcm_ready has no effect.
REQ-014 SHALL run a divider counter 0..BCLK_HALF_DIV-1; at the terminal count i2s_bclk toggles and the counter wraps to 0.
REQ-015 SHALL define a falling event as the cycle in which i2s_bclk toggles 1->0; i2s_sdata, i2s_lrclk and bit_cnt change only on falling events.
REQ-016 SHALL keep a 5-bit bit_cnt, incrementing on each falling event, wrapping 31->0; frame = 32 bclk periods = 64*BCLK_HALF_DIV clk cycles.
REQ-017 SHALL drive i2s_lrclk = 1 when bit_cnt is 15..30, else 0 (word select leads data by one bclk, standard I2S).
REQ-018 SHALL, on the falling event where bit_cnt wraps 31->0, load the frame register from the buffer, empty the buffer, and pulse frame_start in that cycle.
REQ-019 SHALL drive i2s_sdata = frame[15-bit_cnt] for bit_cnt 0..15 (left) and frame[31-bit_cnt] for 16..31 (right); mono: same sample both channels.
REQ-020 SHALL, if the buffer is empty at a frame load, retain the previous frame register value, pulse underrun and frame_start in that cycle.
REQ-021 SHALL evaluate the frame load against buffer state at the start of the cycle: an accept coinciding with a load does not bypass; that sample stays buffered for the next frame and underrun fires if the buffer was empty.
REQ-022 SHALL allow an accept in the same cycle a full buffer is emptied by a load only from the following cycle (pcm_ready reflects registered empty flag).

Reset
REQ-023 SHALL, while reset is high at a clk edge, set i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, frame_start=0, underrun=0, pcm_ready=0, divider=0, bit_cnt=31, frame register=0, buffer empty.
REQ-024 SHALL assert pcm_ready=1 in the first cycle after reset deasserts.
REQ-025 SHALL produce the first falling event, and thus the first frame load, 2*BCLK_HALF_DIV clk cycles after reset deasserts.
REQ-026 SHALL abort any frame in progress on reset with no partial-sample output thereafter; a buffered sample is discarded.

Verification (BCLK_HALF_DIV=2, frame = 128 clk)
REQ-027 SHALL cover: reset 5 cycles -> all outputs 0 during reset, pcm_ready=1 first cycle after, first frame_start 4 cycles after release.
REQ-028 SHALL cover: write 0xA5C3 before first load -> sdata 1010010111000011 at bit_cnt 0..15 and again at 16..31; lrclk low 31,0..14, high 15..30; underrun stays 0.
REQ-029 SHALL cover: no write after reset -> underrun and frame_start pulse together at first load; sdata all 0 for 32 bits; after 0x7FFF once then silence, following frames repeat 0x7FFF with underrun each load.
REQ-030 SHALL cover: pcm_valid held high with 0x1111 then 0x2222 -> 0x1111 accepted, pcm_ready low until next load, 0x2222 accepted the cycle after that load and sent the following frame.
REQ-031 SHALL cover: accept 0x0F0F in exactly the load cycle with empty buffer -> underrun pulses, old sample repeats, 0x0F0F sent next frame.
REQ-032 SHALL cover: reset asserted at bit_cnt 20 with buffered 0x1234 -> outputs return to REQ-023 values next edge, 0x1234 never transmitted, first post-reset load reports underrun.
